lcd_bus_receiver: RTL and testbench
===================================

# lcd_bus_receiver

Synthesizable responder for the 4-bit HD44780-style LCD bus (RS, RW, E, D7–D4) that our LCD writer drives. It sits on the receiving side of that bus in loopback and emulation builds. It captures nibbles on E falling edges and assembles them into bytes. It decodes a command subset and maintains a 32-character display buffer (2×16) that other logic can read, for example a VGA or 7-seg mirror or a test monitor.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for all bus inputs (≥2)
- BUSY_CYCLES, 64, busy duration after each accepted byte; used only with LCD_RX_BUSY_EN

Ports:
- clk  in  1  system clock (40 MHz)
- rst  in  1  reset, asynchronous, active-high
- lcd_rs  in  1  register select (0 = command, 1 = data)
- lcd_rw  in  1  0 = write, 1 = read
- lcd_e  in  1  enable strobe, asynchronous to clk
- lcd_d  in  4  bus bits D7..D4
- rd_addr  in  5  buffer read address (0–15 = row 0, 16–31 = row 1)
- rd_data  out  8  buffer byte at rd_addr, registered
- byte_valid  out  1  one-cycle pulse, a write byte was assembled
- byte_data  out  8  assembled byte, valid with byte_valid
- byte_rs  out  1  RS of the assembled byte, valid with byte_valid
- cursor  out  5  current buffer address
- clearing  out  1  high while a clear-display fill is in progress
- err_drop  out  1  one-cycle pulse, a byte was dropped during clearing
- lcd_d_out  out  4  read-back nibble (macro only)
- lcd_d_oe  out  1  read-back drive enable (macro only)
- busy  out  1  emulated busy flag (macro only)

## Operation
- All bus inputs pass through a SYNC_STAGES flop chain. A falling edge is synchronized E going 1→0.
- RS, RW and D are taken from the synchronized sample aligned with the last E-high sample.
- Nibble phase: the first edge after reset is the high nibble and the next is the low nibble, alternating. RW=1 edges also toggle the phase.
- Write byte completes on the low nibble with RW=0. It pulses byte_valid and is then decoded:
  - RS=1: buf[cursor] ← byte. Then cursor ± 1 per entry-mode I/D, wrapping mod 32 (31→0, 0→31).
  - RS=0, 0x01 clear: enter CLEAR, fill all 32 entries with 0x20, cursor ← 0, I/D ← increment.
  - RS=0, 0x02/0x03 return home: cursor ← 0.
  - RS=0, 0x04–0x07 entry mode: I/D ← byte[1]. Shift bit is ignored.
  - RS=0, 0x80|a: cursor ← {a[6], a[3:0]}.
  - All other commands: byte_valid only, no state change.
- FSM states:
  - IDLE: apply decoded bytes.
  - CLEAR: write one entry per cycle for 32 cycles, then return to IDLE. clearing is high throughout.
- A byte that completes while in CLEAR still pulses byte_valid and err_drop. It is not applied.
- Buffer write and cursor update happen in the same cycle as byte_valid.

## Timing
- Reset values:
  - All buffer entries = 0x20.
  - cursor = 0, I/D = increment, phase = high, state = IDLE.
  - rd_data = 0x00, all pulses = 0, clearing = 0.
  - busy = 0, lcd_d_oe = 0, lcd_d_out = 0.
- Edge detection latency: SYNC_STAGES+1 clk cycles after lcd_e falls.
- byte_valid: one cycle after the low-nibble edge is detected.
- rd_data: reflects buf[rd_addr] one cycle after the address is applied. A write to the same address in a cycle appears on the following read.
- CLEAR lasts exactly 32 cycles. clearing rises the cycle after the 0x01 byte_valid.
- E high pulses must last ≥SYNC_STAGES+1 clk cycles, and so must E low gaps. Shorter pulses are undefined.
- Reset asserted mid-byte discards the pending nibble and returns phase to high.

## Configuration
- LCD_RX_BUSY_EN defined:
  - busy rises with each applied byte_valid and holds for BUSY_CYCLES, or for the CLEAR duration, whichever is longer.
  - While synchronized RW=1 and RS=0 and E is high, lcd_d_oe=1 and lcd_d_out drives the read-back nibble. The high phase drives {busy, cursor[4], 2'b00}; the low phase drives cursor[3:0].
- LCD_RX_BUSY_EN undefined:
  - busy, lcd_d_oe and lcd_d_out are tied to 0, and read edges only toggle the phase.
  - BUSY_CYCLES is unused.

## Structure
- Package lcd_pkg holds:
  - command opcodes: CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_ENTRY=0x04, CMD_DDRAM=0x80
  - CHAR_SPACE=0x20, ROW1_BASE=0x40, BUF_DEPTH=32
  - the FSM state encoding (IDLE, CLEAR)
- Sub-module lcd_sync: a parameterized SYNC_STAGES synchronizer instantiated for {E, RS, RW, D}.

## Test plan
- Reset, then read addresses 0–31 → every rd_data = 0x20; cursor = 0.
- Write RS=1 nibbles 4,1 then 4,2 → byte_valid twice with byte_data 0x41 and 0x42; buf[0]=0x41, buf[1]=0x42, cursor=2.
- Command 0xC5, then data 0x5A → buf[21]=0x5A, cursor=22. Command 0x8F, then 2 data bytes → second byte lands at buf[16]? No: it wraps 15→16, so the second byte lands at buf[16].
- Entry mode 0x04, cursor=0, write 0x31 → buf[0]=0x31 and cursor=31, confirming decrement wrap.
- Fill data, send 0x01, then send a data byte 10 cycles later → clearing high for 32 cycles; err_drop pulses once; all entries read 0x20; cursor=0.
- With LCD_RX_BUSY_EN: write one byte, then issue an RS=0 read pair inside BUSY_CYCLES → high nibble = {1, cursor[4], 00}, lcd_d_oe high only while E high. Repeat the read after BUSY_CYCLES → bit 3 = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared opcodes, buffer constants and FSM state encoding for the LCD bus receiver.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_DDRAM  = 8'h80;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] ROW1_BASE  = 8'h40;
    localparam int         BUF_DEPTH  = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rx_state_t;

    // DDRAM row bit plus column select the flat 0..31 buffer index.
    function automatic logic [4:0] ddram_index(input logic [7:0] cmd);
        return {(cmd & ROW1_BASE) != 8'h00, cmd[3:0]};
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Parameterized multi-flop synchronizer for a bundle of asynchronous inputs.
module lcd_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiving end of the 4-bit HD44780-style LCD bus: nibble capture, command decode, 2x16 buffer.
// Define LCD_RX_BUSY_EN to emulate the busy flag and drive read-back nibbles.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BUSY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [3:0] lcd_d,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic [4:0] cursor,
    output logic       clearing,
    output logic       err_drop,
    output logic [3:0] lcd_d_out,
    output logic       lcd_d_oe,
    output logic       busy
);

    logic [6:0] bus_s;
    logic       e_s, rs_s, rw_s;
    logic [3:0] d_s;

    lcd_sync #(
        .STAGES(SYNC_STAGES),
        .WIDTH (7)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  ({lcd_e, lcd_rs, lcd_rw, lcd_d}),
        .q  (bus_s)
    );

    assign e_s  = bus_s[6];
    assign rs_s = bus_s[5];
    assign rw_s = bus_s[4];
    assign d_s  = bus_s[3:0];

    logic       e_q, rs_q, rw_q;
    logic [3:0] d_q;
    logic       edge_det;
    logic       nib_rs, nib_rw;
    logic [3:0] nib_d;
    logic       phase_high;
    logic [3:0] hi_nib;

    // The *_q copies hold the last E-high sample, so a falling edge latches the bus as it was with E high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            d_q        <= 4'h0;
            edge_det   <= 1'b0;
            nib_rs     <= 1'b0;
            nib_rw     <= 1'b0;
            nib_d      <= 4'h0;
            phase_high <= 1'b1;
            hi_nib     <= 4'h0;
        end else begin
            e_q      <= e_s;
            rs_q     <= rs_s;
            rw_q     <= rw_s;
            d_q      <= d_s;
            edge_det <= e_q & ~e_s;
            if (e_q & ~e_s) begin
                nib_rs <= rs_q;
                nib_rw <= rw_q;
                nib_d  <= d_q;
            end
            if (edge_det) begin
                phase_high <= ~phase_high;
                if (phase_high) begin
                    hi_nib <= nib_d;
                end
            end
        end
    end

    logic [7:0] rx_byte;
    logic       byte_done;

    assign rx_byte   = {hi_nib, nib_d};
    assign byte_done = edge_det && !phase_high && !nib_rw;

    rx_state_t  state;
    logic       inc_mode;
    logic [4:0] clear_idx;
    logic [7:0] buf_mem [BUF_DEPTH];

    // Bytes finishing during CLEAR are reported and flagged but never touch buffer or cursor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cursor     <= 5'd0;
            inc_mode   <= 1'b1;
            clear_idx  <= 5'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
            err_drop   <= 1'b0;
            clearing   <= 1'b0;
            rd_data    <= 8'h00;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= CHAR_SPACE;
            end
        end else begin
            byte_valid <= byte_done;
            err_drop   <= byte_done && (state == CLEAR);
            clearing   <= (state == CLEAR);
            rd_data    <= buf_mem[rd_addr];
            if (byte_done) begin
                byte_data <= rx_byte;
                byte_rs   <= nib_rs;
            end
            case (state)
                IDLE: begin
                    if (byte_done) begin
                        if (nib_rs) begin
                            buf_mem[cursor] <= rx_byte;
                            cursor          <= inc_mode ? cursor + 5'd1 : cursor - 5'd1;
                        end else if (rx_byte == CMD_CLEAR) begin
                            state     <= CLEAR;
                            clear_idx <= 5'd0;
                            cursor    <= 5'd0;
                            inc_mode  <= 1'b1;
                        end else if (rx_byte[7:1] == CMD_HOME[7:1]) begin
                            cursor <= 5'd0;
                        end else if (rx_byte[7:2] == CMD_ENTRY[7:2]) begin
                            inc_mode <= rx_byte[1];
                        end else if ((rx_byte & CMD_DDRAM) != 8'h00) begin
                            cursor <= ddram_index(rx_byte);
                        end
                    end
                end
                CLEAR: begin
                    buf_mem[clear_idx] <= CHAR_SPACE;
                    clear_idx          <= clear_idx + 5'd1;
                    if (clear_idx == 5'(BUF_DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LCD_RX_BUSY_EN
    // A clear keeps busy up until clearing drops, even when BUSY_CYCLES is shorter.
    localparam int CLEAR_BUSY = (BUSY_CYCLES > BUF_DEPTH + 1) ? BUSY_CYCLES : BUF_DEPTH + 1;

    logic [15:0] busy_cnt;
    logic        applied;
    logic        drive_rd;

    assign applied  = byte_done && (state == IDLE);
    assign drive_rd = e_s && rw_s && !rs_s;
    assign busy     = (busy_cnt != 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt  <= 16'd0;
            lcd_d_oe  <= 1'b0;
            lcd_d_out <= 4'h0;
        end else begin
            if (applied) begin
                busy_cnt <= (!nib_rs && rx_byte == CMD_CLEAR) ? 16'(CLEAR_BUSY) : 16'(BUSY_CYCLES);
            end else if (busy_cnt != 16'd0) begin
                busy_cnt <= busy_cnt - 16'd1;
            end
            lcd_d_oe <= drive_rd;
            if (drive_rd) begin
                lcd_d_out <= phase_high ? {busy, cursor[4], 2'b00} : cursor[3:0];
            end else begin
                lcd_d_out <= 4'h0;
            end
        end
    end
`else
    logic busy_cycles_unused;

    assign busy_cycles_unused = (BUSY_CYCLES > 0);
    assign busy      = 1'b0;
    assign lcd_d_oe  = 1'b0;
    assign lcd_d_out = 4'h0;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver against a byte-level model of the LCD command set.
module tb_lcd_bus_receiver;

    localparam int SYNC = 2;
    localparam int BUSY = 64;
    localparam int HOLD = SYNC + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic [3:0] lcd_d = 4'h0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic [4:0] cursor;
    logic       clearing;
    logic       err_drop;
    logic [3:0] lcd_d_out;
    logic       lcd_d_oe;
    logic       busy;

    lcd_bus_receiver #(
        .SYNC_STAGES(SYNC),
        .BUSY_CYCLES(BUSY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_d     (lcd_d),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_rs   (byte_rs),
        .cursor    (cursor),
        .clearing  (clearing),
        .err_drop  (err_drop),
        .lcd_d_out (lcd_d_out),
        .lcd_d_oe  (lcd_d_oe),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       rs;
        logic       drop;
    } exp_t;

    exp_t       expq[$];
    exp_t       head;
    logic [7:0] mbuf [32];
    int         mcur;
    bit         minc;
    bit         mphase_hi;
    logic [3:0] mhi;
    int         clear_v = -1000;
    bit         comparing = 1'b0;
    int         clear_cycles = 0;
    int         drop_pulses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        mcur      = 0;
        minc      = 1'b1;
        mphase_hi = 1'b1;
        clear_v   = -1000;
        expq.delete();
    endfunction

    // Command semantics at byte level; v is the cycle in which the byte is reported.
    function automatic void model_apply(input logic [7:0] b, input logic rs, input int v);
        if (rs) begin
            mbuf[mcur] = b;
            mcur = minc ? (mcur + 1) % 32 : (mcur + 31) % 32;
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
            mcur    = 0;
            minc    = 1'b1;
            clear_v = v;
        end else if (b == 8'h02 || b == 8'h03) begin
            mcur = 0;
        end else if (b >= 8'h04 && b <= 8'h07) begin
            minc = b[1];
        end else if (b >= 8'h80) begin
            mcur = (b[6] ? 16 : 0) + int'(b[3:0]);
        end
    endfunction

    function automatic void model_edge(input logic rs, input logic rw, input logic [3:0] nib, input int fc);
        exp_t e;
        if (mphase_hi) begin
            mhi       = nib;
            mphase_hi = 1'b0;
        end else begin
            mphase_hi = 1'b1;
            if (!rw) begin
                e.cyc  = fc + SYNC + 2;
                e.data = {mhi, nib};
                e.rs   = rs;
                e.drop = (e.cyc > clear_v) && (e.cyc <= clear_v + 32);
                expq.push_back(e);
                if (!e.drop) model_apply(e.data, rs, e.cyc);
            end
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] nib);
        tick(1);
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_d  = nib;
        tick(1);
        lcd_e = 1'b1;
        tick(HOLD);
        lcd_e = 1'b0;
        model_edge(rs, rw, nib, cyc);
        tick(HOLD);
    endtask

    task automatic applyStimulus(input logic rs, input logic [7:0] b);
        send_nibble(rs, 1'b0, b[7:4]);
        send_nibble(rs, 1'b0, b[3:0]);
    endtask

    task automatic read_buf(input int a, output logic [7:0] d);
        rd_addr = 5'(a);
        tick(1);
        d = rd_data;
    endtask

    task automatic check_buffer();
        logic [7:0] d;
        for (int a = 0; a < 32; a++) begin
            read_buf(a, d);
            checkOutput($sformatf("buf[%0d]", a), d, mbuf[a]);
        end
        checkOutput("cursor_model", cursor, mcur);
    endtask

`ifdef LCD_RX_BUSY_EN
    task automatic read_nibble(input string name, input logic [3:0] expected);
        tick(1);
        lcd_rs = 1'b0;
        lcd_rw = 1'b1;
        lcd_d  = 4'h0;
        tick(1);
        lcd_e = 1'b1;
        tick(HOLD);
        checkOutput({name, "_oe_high"}, lcd_d_oe, 1);
        checkOutput({name, "_nibble"}, lcd_d_out, expected);
        lcd_e = 1'b0;
        model_edge(1'b0, 1'b1, 4'h0, cyc);
        tick(HOLD);
        checkOutput({name, "_oe_low"}, lcd_d_oe, 0);
    endtask
`endif

    // Per-cycle comparison of the pulse outputs and the clear window against the model.
    always @(negedge clk) begin
        if (comparing && !rst) begin
            checkOutput("clearing", clearing, (cyc > clear_v) && (cyc <= clear_v + 32));
            if (clearing) clear_cycles++;
            if (err_drop) drop_pulses++;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                head = expq.pop_front();
                checkOutput("byte_valid", byte_valid, 1);
                if (byte_valid) begin
                    checkOutput("byte_data", byte_data, head.data);
                    checkOutput("byte_rs", byte_rs, head.rs);
                    checkOutput("err_drop", err_drop, head.drop);
                end
            end else begin
                checkOutput("byte_valid_idle", byte_valid, 0);
                checkOutput("err_drop_idle", err_drop, 0);
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        model_reset();

        rst = 1'b1;
        tick(3);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        checkOutput("rst_cursor", cursor, 0);
        checkOutput("rst_byte_valid", byte_valid, 0);
        checkOutput("rst_err_drop", err_drop, 0);
        checkOutput("rst_clearing", clearing, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_oe", lcd_d_oe, 0);
        checkOutput("rst_d_out", lcd_d_out, 0);
        rst = 1'b0;
        comparing = 1'b1;
        tick(2);
        check_buffer();
        checkOutput("cursor_after_reset", cursor, 0);

        $display("[TB] two data bytes");
        applyStimulus(1'b1, 8'h41);
        applyStimulus(1'b1, 8'h42);
        tick(4);
        read_buf(0, rd);
        checkOutput("buf0_A", rd, 8'h41);
        read_buf(1, rd);
        checkOutput("buf1_B", rd, 8'h42);
        checkOutput("cursor_AB", cursor, 2);

        $display("[TB] DDRAM addressing and row wrap");
        applyStimulus(1'b0, 8'hC5);
        applyStimulus(1'b1, 8'h5A);
        tick(4);
        read_buf(21, rd);
        checkOutput("buf21", rd, 8'h5A);
        checkOutput("cursor_22", cursor, 22);
        applyStimulus(1'b0, 8'h8F);
        applyStimulus(1'b1, 8'h61);
        applyStimulus(1'b1, 8'h62);
        tick(4);
        read_buf(15, rd);
        checkOutput("buf15", rd, 8'h61);
        read_buf(16, rd);
        checkOutput("buf16_wrap", rd, 8'h62);
        checkOutput("cursor_17", cursor, 17);

        $display("[TB] decrement mode");
        applyStimulus(1'b0, 8'h04);
        applyStimulus(1'b0, 8'h02);
        applyStimulus(1'b1, 8'h31);
        tick(4);
        read_buf(0, rd);
        checkOutput("buf0_dec", rd, 8'h31);
        checkOutput("cursor_wrap_31", cursor, 31);
        applyStimulus(1'b1, 8'h39);
        applyStimulus(1'b0, 8'h06);
        applyStimulus(1'b0, 8'h0C);
        send_nibble(1'b0, 1'b1, 4'hF);
        send_nibble(1'b0, 1'b1, 4'hF);
        applyStimulus(1'b1, 8'h7A);
        tick(4);
        checkOutput("cursor_31_after", cursor, 31);
        check_buffer();

        $display("[TB] clear with a byte arriving mid-clear");
        applyStimulus(1'b0, 8'h01);
        tick(10);
        applyStimulus(1'b1, 8'h55);
        tick(40);
        check_buffer();
        checkOutput("cursor_clear", cursor, 0);
        checkOutput("clear_cycles", clear_cycles, 32);
        checkOutput("drop_pulses", drop_pulses, 1);
        applyStimulus(1'b1, 8'h48);
        tick(4);
        read_buf(0, rd);
        checkOutput("buf0_post_clear", rd, 8'h48);
        checkOutput("cursor_inc_restored", cursor, 1);

        $display("[TB] reset mid-byte");
        send_nibble(1'b1, 1'b0, 4'h7);
        comparing = 1'b0;
        rst = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b0;
        comparing = 1'b1;
        tick(2);
        applyStimulus(1'b1, 8'h37);
        tick(4);
        read_buf(0, rd);
        checkOutput("buf0_after_rst", rd, 8'h37);
        read_buf(1, rd);
        checkOutput("buf1_after_rst", rd, 8'h20);
        checkOutput("cursor_after_rst", cursor, 1);

`ifdef LCD_RX_BUSY_EN
        $display("[TB] busy read-back");
        applyStimulus(1'b1, 8'h38);
        read_nibble("rd_busy_hi", 4'h8);
        read_nibble("rd_busy_lo", 4'h2);
        tick(BUSY + 20);
        read_nibble("rd_idle_hi", 4'h0);
        read_nibble("rd_idle_lo", 4'h2);
`else
        applyStimulus(1'b1, 8'h38);
        tick(4);
        checkOutput("busy_tied", busy, 0);
        checkOutput("oe_tied", lcd_d_oe, 0);
        checkOutput("d_out_tied", lcd_d_out, 0);
`endif

        check_buffer();
        tick(10);
        checkOutput("pending_bytes", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
